// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - decode-side query/issue bundle for fwd_scoreboard
interface fwd_scoreboard_if #(
  parameter int NREG = 32,
  parameter int NSRC = 2,
  parameter int NBYP = 2,
  parameter int LW   = 3
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(NBYP + 1);

  logic                 issue_valid;
  logic                 issue_wen;
  logic [AW-1:0]        issue_rd;
  logic [LW-1:0]        issue_lat;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSRC-1:0]      src_used;
  logic                 flush;
  logic                 stall;
  logic [NSRC*SW-1:0]   fwd_sel;

  modport master (
    output issue_valid, issue_wen, issue_rd, issue_lat, src_addr, src_used, flush,
    input  stall, fwd_sel
  );

  modport slave (
    input  issue_valid, issue_wen, issue_rd, issue_lat, src_addr, src_used, flush,
    output stall, fwd_sel
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - latency-aware RAW/WAW hazard and bypass-select scoreboard
// One countdown per register; a value in 1..NBYP means the result sits on a bypass stage.
module fwd_scoreboard #(
  parameter int NREG = 32,
  parameter int NSRC = 2,
  parameter int NBYP = 2,
  parameter int LW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  fwd_scoreboard_if.slave       dec,
  output logic [NREG-1:0]       pending,
  output logic [31:0]           stall_count
);
  localparam int AW     = $clog2(NREG);
  localparam int MAXLAT = (2 ** LW) - 1;
  localparam int SW     = $clog2(NBYP + 1);
  localparam int CW     = $clog2(MAXLAT + NBYP + 1);

  localparam logic [CW-1:0] NBYP_C  = CW'(NBYP);
  localparam logic [CW-1:0] NBYP1_C = CW'(NBYP + 1);

  logic [CW-1:0] cnt [1:NREG-1];
  logic [CW-1:0] cur [NREG];
  logic [CW-1:0] load_val;
  logic          raw;
  logic          waw;
  logic          accept;
  logic          do_load;

  // Read view with x0 tied to zero so lookups need no special case.
  always_comb begin
    cur[0] = '0;
    for (int r = 1; r < NREG; r++) cur[r] = cnt[r];
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) pending[r] = (cur[r] != '0);
  end

  always_comb begin
    logic [AW-1:0] a;
    logic [CW-1:0] c;
    logic [CW-1:0] d;
    a = '0;
    c = '0;
    d = '0;
    raw = 1'b0;
    dec.fwd_sel = '0;
    for (int s = 0; s < NSRC; s++) begin
      a = dec.src_addr[s*AW +: AW];
      c = cur[a];
      if (dec.src_used[s] && (a != '0)) begin
        if (c > NBYP_C) begin
          raw = 1'b1;
        end else if (c != '0) begin
          d = NBYP1_C - c;
          dec.fwd_sel[s*SW +: SW] = d[SW-1:0];
        end
      end
    end
  end

  // WAW guards against an older, slower write retiring after this one.
  always_comb begin
    load_val  = CW'(dec.issue_lat) + NBYP_C;
    waw       = dec.issue_wen && (dec.issue_rd != '0) && (cur[dec.issue_rd] > load_val);
    dec.stall = dec.issue_valid && !dec.flush && (raw || waw);
    accept    = dec.issue_valid && !dec.flush && !dec.stall;
    do_load   = accept && dec.issue_wen && (dec.issue_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) cnt[r] <= '0;
      stall_count <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (do_load && (dec.issue_rd == AW'(r))) begin
          cnt[r] <= load_val;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
      if (dec.stall) stall_count <= stall_count + 32'd1;
    end
  end
endmodule
